// File: rtl/iob_eth_csr_rd_arb_pkg.sv
// Shared definitions for the Ethernet CSR read arbiter and its helpers.
//   arb_state_e      : arbiter FSM encoding (Idle=0, Issue=1, Wait=2, Hold=3)
//   TimeoutFillBit   : bit value replicated across the data bus on a timed-out read
//   clog2_min1()     : $clog2 clamped to a minimum of 1 for counter/index widths
package iob_eth_csr_rd_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StHold  = 2'd3
  } arb_state_e;

  // A timed-out read returns all ones so software can tell it apart from most real data.
  localparam logic TimeoutFillBit = 1'b1;

  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/iob_eth_rr_pick.sv
// Round-robin pick: scans req_i starting at rr_ptr_i, wrapping modulo N_REQ, and
// returns the first set index.
//   req_i      : request vector
//   rr_ptr_i   : index with highest priority this round
//   grant_o    : chosen index (0 when no request)
//   any_req_o  : at least one request is set
module iob_eth_rr_pick
  import iob_eth_csr_rd_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned PTR_W = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] rr_ptr_i,
  output logic [PTR_W-1:0] grant_o,
  output logic             any_req_o
);

  always_comb begin
    int unsigned idx;
    grant_o   = '0;
    any_req_o = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = (32'(rr_ptr_i) + off) % N_REQ;
      if (!any_req_o && req_i[idx]) begin
        grant_o   = PTR_W'(idx);
        any_req_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iob_eth_csr_rd_arbiter.sv
// Shares the Ethernet core's single non-auto CSR read channel between N_REQ requesters.
// One read is in flight at a time; the returned word is held for the granted requester
// until it accepts it, and a silent core is cut off after TIMEOUT cycles (0 = never).
//   clk_i / cke_i / rst_i     : clock, clock enable, synchronous active-high reset
//   req_valid_i / req_addr_i  : per-requester read request and address
//   req_ready_o               : request accepted by the core (one-hot or zero)
//   req_rdata_o / req_rvalid_o: held read data and per-requester data valid
//   req_rready_i              : per-requester data accept
//   int_*                     : read port towards the core
//   busy_o                    : transaction in flight
//   timeout_o                 : one-cycle pulse on a timed-out read
module iob_eth_csr_rd_arbiter
  import iob_eth_csr_rd_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    rst_i,

  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [DATA_W-1:0]       req_rdata_o,
  output logic [N_REQ-1:0]        req_rvalid_o,
  input  logic [N_REQ-1:0]        req_rready_i,

  output logic                    int_ren_o,
  output logic [ADDR_W-1:0]       int_addr_o,
  input  logic                    int_ready_i,
  input  logic [DATA_W-1:0]       int_rdata_i,
  input  logic                    int_rvalid_i,

  output logic                    busy_o,
  output logic                    timeout_o
);

  localparam int unsigned PtrW       = clog2_min1(N_REQ);
  localparam int unsigned TmrW       = clog2_min1(TIMEOUT + 1);
  localparam int unsigned TmrLastInt = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TmrLastInt);
  localparam logic [PtrW-1:0] LastReq = PtrW'(N_REQ - 1);
  localparam bit              TmrEn   = (TIMEOUT != 0);

  arb_state_e         state_q, state_d;
  logic [PtrW-1:0]    grant_q, grant_d;
  logic [PtrW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [TmrW-1:0]    timer_q, timer_d;

  logic [PtrW-1:0]    pick_grant;
  logic               pick_any;
  logic               gnt_valid;
  logic [ADDR_W-1:0]  gnt_addr;
  logic               accept;
  logic               timeout_hit;

  iob_eth_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PtrW)
  ) u_rr_pick (
    .req_i     (req_valid_i),
    .rr_ptr_i  (rr_ptr_q),
    .grant_o   (pick_grant),
    .any_req_o (pick_any)
  );

  assign gnt_valid   = req_valid_i[grant_q];
  assign gnt_addr    = req_addr_i[32'(grant_q)*ADDR_W +: ADDR_W];
  assign accept      = (state_q == StIssue) && gnt_valid && int_ready_i;
  assign timeout_hit = TmrEn && (state_q == StWait) && !int_rvalid_i && (timer_q == TmrLast);

  // Next-state
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    timer_d  = timer_q;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          grant_d = pick_grant;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (!gnt_valid) begin
          // Requester withdrew before the core took it: nothing issued, priority kept.
          state_d = StIdle;
        end else if (int_ready_i) begin
          timer_d = '0;
          if (int_rvalid_i) begin
            data_d  = int_rdata_i;
            state_d = StHold;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (int_rvalid_i) begin
          data_d  = int_rdata_i;
          state_d = StHold;
        end else if (timeout_hit) begin
          data_d  = {DATA_W{TimeoutFillBit}};
          state_d = StHold;
        end else if (TmrEn) begin
          timer_d = timer_q + 1'b1;
        end
      end
      StHold: begin
        if (req_rready_i[grant_q]) begin
          rr_ptr_d = (grant_q == LastReq) ? '0 : grant_q + 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs are masked while the clock is disabled: a handshake the FSM
  // cannot register would otherwise be seen twice by the other side.
  always_comb begin
    req_ready_o  = '0;
    req_rvalid_o = '0;
    int_ren_o    = 1'b0;
    int_addr_o   = '0;
    timeout_o    = cke_i && timeout_hit;
    busy_o       = (state_q != StIdle);
    req_rdata_o  = data_q;
    if (state_q == StIssue) begin
      int_ren_o            = cke_i && gnt_valid;
      int_addr_o           = gnt_addr;
      req_ready_o[grant_q] = cke_i && accept;
    end
    if (state_q == StHold) begin
      req_rvalid_o[grant_q] = cke_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) begin
        state_q  <= StIdle;
        grant_q  <= '0;
        rr_ptr_q <= '0;
        data_q   <= '0;
        timer_q  <= '0;
      end else begin
        state_q  <= state_d;
        grant_q  <= grant_d;
        rr_ptr_q <= rr_ptr_d;
        data_q   <= data_d;
        timer_q  <= timer_d;
      end
    end
  end

endmodule
